// File: rtl/attn_pkg.sv
// Shared types and default widths for the attention-engine dot-product blocks.
package attn_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PROD_WIDTH_DEF = 16;
    localparam int ACC_WIDTH_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dot_state_e;

endpackage

// File: rtl/dot_slot_pipe.sv
// Tag shift register tracking issued MAC slots; the output tap marks the cycle
// whose mac_sum belongs to a real slot. Latency DEPTH cycles, never stalls.
module dot_slot_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tag,
    output logic o_tag
);

    logic [DEPTH-1:0] r_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_tag = r_sr[DEPTH-1];

endmodule

// File: rtl/dot_issue_ctrl.sv
// Packs q/k element pairs into two-lane MAC slots and accumulates the returned sums.
// Result valid N+MAC_LAT+1 cycles after start with continuous input; s_ready drops once vec_len accepted.
// SATURATE_EN: accumulator clamps and r_sat flags it; otherwise the accumulator wraps.
module dot_issue_ctrl
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH  = 10,
    parameter int MAC_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_q,
    input  logic [DATA_WIDTH-1:0] s_k,
    output logic                  mac_ebl,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic [DATA_WIDTH-1:0] mac_c,
    output logic [DATA_WIDTH-1:0] mac_d,
    input  logic [PROD_WIDTH-1:0] mac_sum,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [ACC_WIDTH-1:0]  r_data,
    output logic                  r_sat
);

    localparam int DCNT_W = $clog2(MAC_LAT + 1);

    dot_state_e            r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_len, r_cnt;
    logic                  r_half;
    logic [DATA_WIDTH-1:0] r_lo_q, r_lo_k;
    logic [DATA_WIDTH-1:0] r_a, r_b, r_c, r_d;
    logic [DCNT_W-1:0]     r_dcnt;
    logic                  r_ebl;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  w_accept, w_last, w_issue, w_tap, w_start;

    assign s_ready  = (r_state == ISSUE) && (r_cnt < r_len);
    assign w_accept = s_valid && s_ready;
    assign w_last   = (r_cnt == r_len - LEN_WIDTH'(1));
    // A pair completes on the second element; an odd final element goes out alone.
    assign w_issue  = w_accept && (r_half || w_last);
    assign w_start  = (r_state == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (start) w_state_nxt = (vec_len == '0) ? DONE : ISSUE;
            ISSUE: if (w_issue && w_last) w_state_nxt = DRAIN;
            DRAIN: if (r_dcnt == DCNT_W'(MAC_LAT)) w_state_nxt = DONE;
            DONE:  if (r_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_half <= 1'b0;
            r_lo_q <= '0;
            r_lo_k <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_d    <= '0;
            r_dcnt <= '0;
            r_ebl  <= 1'b0;
        end else begin
            r_ebl  <= (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN);
            r_dcnt <= (r_state == DRAIN) ? r_dcnt + DCNT_W'(1) : '0;
            if (w_start) begin
                r_len  <= vec_len;
                r_cnt  <= '0;
                r_half <= 1'b0;
            end else if (w_accept) begin
                r_cnt  <= r_cnt + LEN_WIDTH'(1);
                r_half <= !w_issue;
                if (!w_issue) begin
                    r_lo_q <= s_q;
                    r_lo_k <= s_k;
                end
            end
            if (w_issue && r_half) begin
                r_a <= r_lo_q;
                r_b <= r_lo_k;
                r_c <= s_q;
                r_d <= s_k;
            end else if (w_issue) begin
                r_a <= s_q;
                r_b <= s_k;
                r_c <= '0;
                r_d <= '0;
            end else begin
                r_a <= '0;
                r_b <= '0;
                r_c <= '0;
                r_d <= '0;
            end
        end
    end

    dot_slot_pipe #(.DEPTH(MAC_LAT)) u_slot_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_issue),
        .o_tag (w_tap)
    );

`ifdef SATURATE_EN
    logic [ACC_WIDTH:0] w_sum;
    logic               r_sat_hold;

    assign w_sum = {1'b0, r_acc} + (ACC_WIDTH+1)'(mac_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_sat_hold <= 1'b0;
        end else if (w_start) begin
            r_acc      <= '0;
            r_sat_hold <= 1'b0;
        end else if (w_tap) begin
            if (w_sum[ACC_WIDTH]) begin
                r_acc      <= '1;
                r_sat_hold <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_WIDTH-1:0];
            end
        end
    end

    assign r_sat = r_sat_hold;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_acc <= '0;
        else if (w_start) r_acc <= '0;
        else if (w_tap)   r_acc <= r_acc + ACC_WIDTH'(mac_sum);
    end

    assign r_sat = 1'b0;
`endif

    assign mac_ebl = r_ebl;
    assign mac_a   = r_a;
    assign mac_b   = r_b;
    assign mac_c   = r_c;
    assign mac_d   = r_d;
    assign r_valid = (r_state == DONE);
    assign r_data  = r_acc;

endmodule

// File: tb/tb_dot_issue_ctrl.sv
// Directed bench for dot_issue_ctrl with a behavioural two-lane MAC (latency 2).
module tb_dot_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  vec_len = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_q = '0;
    logic [7:0]  s_k = '0;
    logic        mac_ebl;
    logic [7:0]  mac_a, mac_b, mac_c, mac_d;
    logic [15:0] mac_sum;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [15:0] r_data;
    logic        r_sat;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  tq [8];
    logic [7:0]  tk [8];
    int          g_vcyc;
    int          g_ebl;
    logic [31:0] g_slots [$];

    always #5 clk = ~clk;

    // External MAC: a*b + c*d truncated to 16 bits, one register stage + issue register = latency 2.
    logic [15:0] mac_pipe = '0;
    always @(posedge clk) mac_pipe <= 16'(32'(mac_a) * 32'(mac_b) + 32'(mac_c) * 32'(mac_d));
    assign mac_sum = mac_pipe;

    dot_issue_ctrl #(
        .DATA_WIDTH (8),
        .PROD_WIDTH (16),
        .ACC_WIDTH  (16),
        .LEN_WIDTH  (10),
        .MAC_LAT    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .vec_len (vec_len),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_q     (s_q),
        .s_k     (s_k),
        .mac_ebl (mac_ebl),
        .mac_a   (mac_a),
        .mac_b   (mac_b),
        .mac_c   (mac_c),
        .mac_d   (mac_d),
        .mac_sum (mac_sum),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_data  (r_data),
        .r_sat   (r_sat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_mac_ebl"}, 32'(mac_ebl), 32'd0);
        chk({tag, "_mac_ops"}, {mac_a, mac_b, mac_c, mac_d}, 32'd0);
        chk({tag, "_r_valid"}, 32'(r_valid), 32'd0);
        chk({tag, "_r_data"},  32'(r_data), 32'd0);
        chk({tag, "_r_sat"},   32'(r_sat), 32'd0);
    endtask

    // Entered and left at posedge+1. Observation index c counts edges after the start edge.
    task automatic do_run(input int len, input logic [15:0] vpat, input int rst_at);
        int idx;
        bit will;
        idx = 0;
        g_vcyc = -1;
        g_ebl = 0;
        g_slots.delete();
        start = 1'b1;
        vec_len = 10'(len);
        s_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (mac_ebl) g_ebl++;
            if ({mac_a, mac_b, mac_c, mac_d} != 32'd0) g_slots.push_back({mac_a, mac_b, mac_c, mac_d});
            if (c == rst_at) begin
                rst = 1'b1;
                s_valid = 1'b0;
                #1;
                chk_reset_outputs("mid_rst");
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (r_valid) begin
                g_vcyc = c;
                break;
            end
            s_valid = ((c < 16) ? vpat[c] : 1'b1) && (idx < len);
            s_q = tq[(idx < 8) ? idx : 7];
            s_k = tk[(idx < 8) ? idx : 7];
            will = s_valid && s_ready;
            @(posedge clk); #1;
            if (will) idx++;
        end
        s_valid = 1'b0;
    endtask

    task automatic consume(input string tag);
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        chk(tag, 32'(r_valid), 32'd0);
    endtask

    function automatic logic [31:0] slot(input int i);
        return (g_slots.size() > i) ? g_slots[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        #2;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Even length, continuous input
        tq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        tk = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
        do_run(4, 16'hFFFF, -1);
        chk("t1_latency", 32'(g_vcyc), 32'd7);
        chk("t1_r_data", 32'(r_data), 32'd70);
        chk("t1_nslots", 32'(g_slots.size()), 32'd2);
        chk("t1_slot0", slot(0), {8'd1, 8'd5, 8'd2, 8'd6});
        chk("t1_slot1", slot(1), {8'd3, 8'd7, 8'd4, 8'd8});
        chk("t1_ebl_cycles", 32'(g_ebl), 32'd7);
        consume("t1_idle");

        // Odd length: final element issues alone
        tq = '{8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tk = '{8'd10, 8'd10, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_run(3, 16'hFFFF, -1);
        chk("t2_latency", 32'(g_vcyc), 32'd6);
        chk("t2_r_data", 32'(r_data), 32'd90);
        chk("t2_slot0", slot(0), {8'd2, 8'd10, 8'd3, 8'd10});
        chk("t2_slot1", slot(1), {8'd4, 8'd10, 8'd0, 8'd0});
        consume("t2_idle");

        // Gapped input 1-0-0-1-1-0-1
        tq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        tk = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
        do_run(4, 16'hFFD9, -1);
        chk("t3_latency", 32'(g_vcyc), 32'd10);
        chk("t3_r_data", 32'(r_data), 32'd70);
        chk("t3_nslots", 32'(g_slots.size()), 32'd2);
        chk("t3_slot0", slot(0), {8'd1, 8'd5, 8'd2, 8'd6});
        chk("t3_slot1", slot(1), {8'd3, 8'd7, 8'd4, 8'd8});
        chk("t3_ebl_cycles", 32'(g_ebl), 32'd10);
        consume("t3_idle");

        // Zero length, then result held under backpressure with start ignored
        do_run(0, 16'hFFFF, -1);
        chk("t4_latency", 32'(g_vcyc), 32'd0);
        chk("t4_r_data", 32'(r_data), 32'd0);
        chk("t4_ebl_cycles", 32'(g_ebl), 32'd0);
        start = 1'b1;
        vec_len = 10'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", 32'(r_valid), 32'd1);
            chk("t4_hold_data", 32'(r_data), 32'd0);
            chk("t4_hold_ebl", 32'(mac_ebl), 32'd0);
        end
        start = 1'b0;
        consume("t4_idle");

        // Overflow: two slots of 64514 in a 16-bit accumulator
        tq = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
        tk = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
        do_run(4, 16'hFFFF, -1);
        chk("t5_latency", 32'(g_vcyc), 32'd7);
`ifdef SATURATE_EN
        chk("t5_r_data", 32'(r_data), 32'd65535);
        chk("t5_r_sat", 32'(r_sat), 32'd1);
`else
        chk("t5_r_data", 32'(r_data), 32'd63492);
        chk("t5_r_sat", 32'(r_sat), 32'd0);
`endif
        consume("t5_idle");

        // Reset during DRAIN, then a clean short run
        tq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        tk = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
        do_run(4, 16'hFFFF, 5);
        chk("t6_after_rst_valid", 32'(r_valid), 32'd0);
        chk("t6_after_rst_data", 32'(r_data), 32'd0);
        tq = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tk = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_run(2, 16'hFFFF, -1);
        chk("t6_latency", 32'(g_vcyc), 32'd5);
        chk("t6_r_data", 32'(r_data), 32'd2);
        chk("t6_r_sat", 32'(r_sat), 32'd0);
        consume("t6_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
